hex_scan_driver: RTL
====================

# hex_scan_driver

Time-multiplexed driver for a bank of common-anode or common-cathode 7-segment digits sharing one segment bus. It takes a packed hexadecimal value of `DIGITS` nibbles and scans the digits at a programmable rate. New values are double-buffered so that a display update never tears mid-frame. It supports per-digit blanking and sits between the datapath result registers and the board's segment and digit-select pins.

## Interface
- `DIGITS`, default 4: number of digits scanned, legal range 1..8.
- `SCAN_DIV`, default 50000: clock cycles each digit stays enabled, minimum 2.
- `ACTIVE_LOW`, default 1: when 1, `seg` and `dig_en` are inverted at the outputs (0 = lit/selected).
- `clk`  in  1: system clock, all state on rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `load`  in  1: single-cycle strobe; `value` is captured this cycle.
- `value`  in  4*DIGITS: packed nibbles; nibble i (`value[4i+3:4i]`) drives digit i; digit 0 is least significant.
- `blank_mask`  in  DIGITS: bit i = 1 forces digit i dark; sampled live.
- `seg`  out  7: segment bus `{a,b,c,d,e,f,g}`, registered.
- `dig_en`  out  DIGITS: one-hot digit select, registered.
- `frame_tick`  out  1: one-cycle pulse on each frame wrap.

## Operation
- **Prescaler `pcnt`.** Counts 0..SCAN_DIV-1 and wraps to 0. The terminal count (`pcnt==SCAN_DIV-1`) is the advance event.
- **Digit index `idx`.** Width max(1,$clog2(DIGITS)). On an advance it increments 0..DIGITS-1 and wraps to 0. An advance with `idx==DIGITS-1` is a frame wrap.
- **Staging register and `pending` flag.**
  - `load=1` captures `value` into staging and sets `pending`.
  - Back-to-back loads overwrite staging; the last one wins.
- **Shadow register.** This is the displayed value. It changes only on a frame wrap:
  - If `load=1` on the wrap edge, shadow takes `value` directly; staging is also written.
  - Otherwise, if `pending=1`, shadow takes staging.
  - `pending` clears on every wrap.
- **Glyphs.** Standard hex set, raw active-high `{a..g}`:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111
- **Segment output.** Every cycle, `seg` registers the glyph of shadow nibble `idx_next`. It registers all-off (raw 0000000) when `blank_mask[idx_next]=1`. Polarity is applied after blanking.
- **Digit select.** `dig_en` registers the one-hot of `idx_next`, with polarity applied. The selected digit stays enabled even when blanked.
- **Blanking mask.** Changes to `blank_mask` affect `seg` one cycle later. No frame synchronisation is applied to it.

## Timing
- **Reset values.**
  - `pcnt=0`, `idx=0`, staging=0, shadow=0, `pending=0`, `frame_tick=0`.
  - `dig_en` selects digit 0.
  - `seg` shows the glyph "0".
  - Both outputs are polarity-adjusted; e.g. with `ACTIVE_LOW=1`, `dig_en=4'b1110` and `seg=7'b0000001`.
- **Reset mid-operation.** Asynchronous assertion forces all of the above immediately. The first advance occurs SCAN_DIV cycles after release.
- **Advance latency.** `dig_en` and `seg` change on the same edge as the advance. There is no skew between them.
- **Frame timing.** A frame is DIGITS×SCAN_DIV cycles. `frame_tick` is high for exactly the one cycle following a frame-wrap edge.
- **Load-to-display latency.**
  - Worst case is one frame plus 1 cycle.
  - A load on the wrap edge is visible on that edge's outputs. `seg` is computed from the new shadow, so no stale-digit glitch is allowed.
- **DIGITS=1.** `idx` stays 0 and every advance is a frame wrap.

## Configuration
- `HEXSCAN_LZB_EN`: leading-zero blanking.
  - **Defined:** any digit i>0 is dark when shadow nibbles i..DIGITS-1 are all zero. This is computed from shadow and ORed with `blank_mask`. Digit 0 is never auto-blanked, so 0 displays as a single "0".
  - **Undefined:** no such logic exists; only `blank_mask` blanks.

## Test plan
Bench setup: `DIGITS=4`, `SCAN_DIV=4`, `ACTIVE_LOW=1`.
- **Reset.** Assert `rst_n=0` → `dig_en=1110`, `seg=0000001`, `frame_tick=0`. After release, first `dig_en` change is exactly 4 cycles later, and `frame_tick` first pulses at cycle 16.
- **Scan and deferred update.** `load` 0x1A3F mid-frame → display unchanged until the next wrap, then digits 0..3 show F,3,A,1. Digit 0 shows `seg=0111000` while `dig_en=1110`.
- **Load on wrap edge.** `load` 0xBEEF coincident with the wrap edge → the post-wrap digit-0 `seg` is the glyph for F, with no one-cycle stale value; `pending=0` afterward.
- **Back-to-back loads.** Loads 0x1111 then 0x2222 in consecutive cycles within one frame → the next frame shows only 2222.
- **Blanking.** `blank_mask=0100` with shadow 0x8888 → digit 2 `seg=1111111` while `dig_en=1011`. Other digits show 0000000.
- **Leading-zero blanking (with `HEXSCAN_LZB_EN`).** Shadow 0x0050 → digits 3 and 2 dark, digits 1 and 0 show 5 and 0. Shadow 0x0000 → only digit 0 shows "0". Without the macro, all four digits are lit.

Source files
------------

// File: rtl/hex_scan_driver.sv
// hex_scan_driver: time-multiplexed driver for a bank of 7-segment digits
// that share one segment bus.
//
// A prescaler sets how long each digit stays selected. The digit index steps
// once per prescaler wrap. The displayed value is held in a shadow register
// that only changes at a frame wrap, so a new value never tears mid-frame.
//
// Optional feature macro:
//   HEXSCAN_LZB_EN - leading-zero blanking. Digit i>0 goes dark when shadow
//                    nibbles i..DIGITS-1 are all zero. This is ORed with
//                    blank_mask. Digit 0 is never auto-blanked.
//
// load semantics: load is a single-cycle strobe with no back-pressure.
// value is captured on every rising edge where load=1. Loads in consecutive
// cycles overwrite each other, and the last one wins.
module hex_scan_driver #(
  parameter int DIGITS     = 4,
  parameter int SCAN_DIV   = 50000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     blank_mask,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     dig_en,
  output logic                  frame_tick
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = $clog2(SCAN_DIV);

  localparam logic [PW-1:0]     PCNT_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]     IDX_LAST  = IW'(DIGITS - 1);
  localparam logic [6:0]        SEG_RST   = ACTIVE_LOW ? 7'b0000001 : 7'b1111110;
  localparam logic [DIGITS-1:0] DIG_ONE   = DIGITS'(1);
  localparam logic [DIGITS-1:0] DIG_RST   = ACTIVE_LOW ? ~DIG_ONE : DIG_ONE;

  // Raw active-high glyph {a,b,c,d,e,f,g} for one hex nibble.
  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'b1111110;
      4'h1: g = 7'b0110000;
      4'h2: g = 7'b1101101;
      4'h3: g = 7'b1111001;
      4'h4: g = 7'b0110011;
      4'h5: g = 7'b1011011;
      4'h6: g = 7'b1011111;
      4'h7: g = 7'b1110000;
      4'h8: g = 7'b1111111;
      4'h9: g = 7'b1111011;
      4'hA: g = 7'b1110111;
      4'hB: g = 7'b0011111;
      4'hC: g = 7'b1001110;
      4'hD: g = 7'b0111101;
      4'hE: g = 7'b1001111;
      default: g = 7'b1000111;
    endcase
    return g;
  endfunction

  logic [PW-1:0]       pcnt;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] staging;
  logic [4*DIGITS-1:0] shadow;
  logic                pending;

  logic                advance;
  logic                wrap;
  logic [IW-1:0]       idx_next;
  logic [4*DIGITS-1:0] shadow_next;
  logic [3:0]          nib;
  logic                blk;
  logic [DIGITS-1:0]   onehot;
  logic [6:0]          seg_raw;
  logic [6:0]          seg_next;
  logic [DIGITS-1:0]   dig_next;
`ifdef HEXSCAN_LZB_EN
  logic [DIGITS-1:0]   lzb;
  logic                hi_zero;
`endif

  // Next index, next shadow, and the glyph that the next edge will drive.
  // seg is computed from the post-wrap shadow, so a load on the wrap edge
  // shows up on that same edge with no stale digit.
  always_comb begin
    advance     = (pcnt == PCNT_LAST);
    wrap        = advance && (idx == IDX_LAST);
    idx_next    = idx;
    if (advance) begin
      idx_next = (idx == IDX_LAST) ? '0 : idx + IW'(1);
    end

    shadow_next = shadow;
    if (wrap) begin
      if (load) begin
        shadow_next = value;
      end else if (pending) begin
        shadow_next = staging;
      end
    end

`ifdef HEXSCAN_LZB_EN
    lzb     = '0;
    hi_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      hi_zero = hi_zero && (shadow_next[4*i +: 4] == 4'h0);
      lzb[i]  = hi_zero;
    end
`endif

    nib    = 4'h0;
    blk    = 1'b0;
    onehot = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_next == IW'(i)) begin
        nib       = shadow_next[4*i +: 4];
`ifdef HEXSCAN_LZB_EN
        blk       = blank_mask[i] | lzb[i];
`else
        blk       = blank_mask[i];
`endif
        onehot[i] = 1'b1;
      end
    end

    seg_raw  = blk ? 7'b0000000 : glyph(nib);
    seg_next = ACTIVE_LOW ? ~seg_raw : seg_raw;
    dig_next = ACTIVE_LOW ? ~onehot : onehot;
  end

  // Prescaler, digit index, and the registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt       <= '0;
      idx        <= '0;
      seg        <= SEG_RST;
      dig_en     <= DIG_RST;
      frame_tick <= 1'b0;
    end else begin
      pcnt       <= advance ? '0 : pcnt + PW'(1);
      idx        <= idx_next;
      seg        <= seg_next;
      dig_en     <= dig_next;
      frame_tick <= wrap;
    end
  end

  // Double buffer: staging collects loads, and shadow commits at the frame wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      staging <= '0;
      shadow  <= '0;
      pending <= 1'b0;
    end else begin
      if (load) begin
        staging <= value;
      end
      shadow <= shadow_next;
      if (wrap) begin
        pending <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

endmodule
